// File: rtl/decoder_frame_sched.sv
// -----------------------------------------------------------------------------
// decoder_frame_sched
//
// Buffers complete coded frames from the host in a small FIFO. Each frame is
// replayed to the turbo decoder as BEATS consecutive beats with start held
// high. The block then waits for the decoder's done under a timeout and
// presents the decoded result (or a timeout marker) on a valid/ready port.
//
// Ports
//   clk_p_i, reset_n_i          clock (rising edge), async active-low reset
//   frm_valid_i/frm_data_i      host frame in; beat k = bits [(k+1)*BEAT_W-1 -: BEAT_W]
//   frm_ready_o                 FIFO has room (decoded from the count register)
//   dec_start_o/dec_data_o      beat stream to the decoder (registered)
//   dec_done_i/dec_data_i       decoder completion and decoded value
//   res_valid_o/res_data_o      result out; res_data_o is 0 on timeout
//   res_timeout_o               result is a timeout marker
//   res_ready_i                 result consumer ready
//   busy_o                      scheduler is not idle
//   frm_count_o                 frames currently held in the FIFO
// -----------------------------------------------------------------------------
module decoder_frame_sched #(
    parameter int FRAME_DEPTH = 4,
    parameter int BEATS       = 4,
    parameter int BEAT_W      = 21,
    parameter int OUT_W       = 5,
    parameter int TIMEOUT     = 1023
) (
    input  logic                          clk_p_i,
    input  logic                          reset_n_i,
    input  logic                          frm_valid_i,
    input  logic [BEATS*BEAT_W-1:0]       frm_data_i,
    output logic                          frm_ready_o,
    output logic                          dec_start_o,
    output logic [BEAT_W-1:0]             dec_data_o,
    input  logic                          dec_done_i,
    input  logic [OUT_W-1:0]              dec_data_i,
    output logic                          res_valid_o,
    output logic [OUT_W-1:0]              res_data_o,
    output logic                          res_timeout_o,
    input  logic                          res_ready_i,
    output logic                          busy_o,
    output logic [$clog2(FRAME_DEPTH):0]  frm_count_o
);

    localparam int PTR_W   = $clog2(FRAME_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TMO_W   = $clog2(TIMEOUT + 1);
    localparam int FRAME_W = BEATS * BEAT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e               state_q, state_d;
    logic [BEAT_CW-1:0]   beat_q, beat_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 dec_start_q, dec_start_d;
    logic [BEAT_W-1:0]    dec_data_q, dec_data_d;
    logic                 res_valid_q, res_valid_d;
    logic [OUT_W-1:0]     res_data_q, res_data_d;
    logic                 res_timeout_q, res_timeout_d;

    logic [FRAME_W-1:0]   mem_q [FRAME_DEPTH];
    logic [FRAME_W-1:0]   head_frame;
    logic [BEAT_W-1:0]    head_beats [BEATS];
    logic                 push, pop, load_beat;

    assign frm_ready_o = (count_q != CNT_W'(FRAME_DEPTH));
    assign push        = frm_valid_i & frm_ready_o;

    // With an empty FIFO the only way to enter LOAD is a HOLD handshake that
    // coincides with a push; the frame is not in the array yet, so bypass it.
    assign head_frame = (count_q == '0) ? frm_data_i : mem_q[rd_ptr_q];

    for (genvar k = 0; k < BEATS; k++) begin : g_beat
        assign head_beats[k] = head_frame[k*BEAT_W +: BEAT_W];
    end

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        tmo_d         = tmo_q;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        pop           = 1'b0;
        load_beat     = 1'b0;
        dec_start_d   = 1'b0;
        dec_data_d    = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d   = ST_LOAD;
                    beat_d    = '0;
                    load_beat = 1'b1;
                end
            end
            ST_LOAD: begin
                if (beat_q == BEAT_CW'(BEATS - 1)) begin
                    pop     = 1'b1;
                    state_d = ST_WAIT;
                    tmo_d   = '0;
                end else begin
                    beat_d    = beat_q + BEAT_CW'(1);
                    load_beat = 1'b1;
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + TMO_W'(1);
                // done is checked first so it wins over a coincident timeout
                if (dec_done_i) begin
                    res_valid_d   = 1'b1;
                    res_data_d    = dec_data_i;
                    res_timeout_d = 1'b0;
                    state_d       = ST_HOLD;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    res_valid_d   = 1'b1;
                    res_data_d    = '0;
                    res_timeout_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    if ((count_q != '0) || push) begin
                        state_d   = ST_LOAD;
                        beat_d    = '0;
                        load_beat = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Beat outputs are registered, so they are computed from the beat
        // index the LOAD state will hold next cycle.
        if (load_beat) begin
            dec_start_d = 1'b1;
            dec_data_d  = head_beats[beat_d];
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop in
    // this block samples the pre-edge values of the others.
    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= ST_IDLE;
            beat_q        <= '0;
            tmo_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            dec_start_q   <= 1'b0;
            dec_data_q    <= '0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            tmo_q         <= tmo_d;
            count_q       <= count_d;
            dec_start_q   <= dec_start_d;
            dec_data_q    <= dec_data_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    // NOTE: the frame array has no reset; an entry is only read after it has
    // been written, because the count (which is reset) guards every read.
    always_ff @(posedge clk_p_i) begin
        if (push) mem_q[wr_ptr_q] <= frm_data_i;
    end

    assign dec_start_o   = dec_start_q;
    assign dec_data_o    = dec_data_q;
    assign res_valid_o   = res_valid_q;
    assign res_data_o    = res_data_q;
    assign res_timeout_o = res_timeout_q;
    assign frm_count_o   = count_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule
